lcd_cmd_sequencer: RTL and testbench



---
 rtl/lcd_cmd_sequencer_if.sv | 34 +++
 rtl/lcd_cmd_sequencer.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : lcd_cmd_sequencer_if
// Brief   : host byte port plus Lcd_Controller strobe/handshake and LCD bus
// Revision: 1.0
// ============================================================================
interface lcd_cmd_sequencer_if;
  logic       host_valid;
  logic       host_rs;
  logic [7:0] host_data;
  logic       host_ready;
  logic       init_done;
  logic       err;
  logic       nCS;
  logic       nWR;
  logic       nRD;
  logic       RS;
  logic       RDY;
  logic [7:0] db_out;
  logic       db_oe;
  logic [7:0] db_in;

  // master: the sequencer; slave: host and controller side
  modport master (
    input  host_valid, host_rs, host_data, RDY, db_in,
    output host_ready, init_done, err, nCS, nWR, nRD, RS, db_out, db_oe
  );

  modport slave (
    output host_valid, host_rs, host_data, RDY, db_in,
    input  host_ready, init_done, err, nCS, nWR, nRD, RS, db_out, db_oe
  );
endinterface
`default_nettype wire

// File: rtl/lcd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : lcd_cmd_sequencer
// Brief   : HD44780 power-on init, then busy-polled host byte writes
// Revision: 1.0
// ============================================================================
module lcd_cmd_sequencer #(
  parameter int PWRUP_CYC   = 750000,
  parameter int LONG_CYC    = 205000,
  parameter int SHORT_CYC   = 5000,
  parameter int POLL_GAP    = 16,
  parameter int ACK_TIMEOUT = 255,
  parameter int BF_MAX      = 1023
) (
  input  wire                 clk,
  input  wire                 rst,
  lcd_cmd_sequencer_if.master bus
);

  localparam int c_MAX_A = (PWRUP_CYC > LONG_CYC) ? PWRUP_CYC : LONG_CYC;
  localparam int c_MAX_B = (SHORT_CYC > POLL_GAP) ? SHORT_CYC : POLL_GAP;
  localparam int c_MAX_C = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
  localparam int c_MAXD  = (c_MAX_C > ACK_TIMEOUT) ? c_MAX_C : ACK_TIMEOUT;
  localparam int c_CW    = $clog2(c_MAXD + 1);
  localparam int c_PW    = $clog2(BF_MAX + 1);
  localparam logic [2:0] c_LAST_FIXED = 3'd2;
  localparam logic [2:0] c_LAST_INIT  = 3'd6;

  typedef enum logic [2:0] {
    PWR   = 3'd0,
    ISSUE = 3'd1,
    ACK   = 3'd2,
    DONE  = 3'd3,
    DELAY = 3'd4,
    POLL  = 3'd5,
    IDLE  = 3'd6
  } state_t;

  function automatic logic [7:0] initRom(input logic [2:0] idx);
    case (idx)
      3'd4:    initRom = 8'h0C;
      3'd5:    initRom = 8'h01;
      3'd6:    initRom = 8'h06;
      default: initRom = 8'h38;
    endcase
  endfunction

  state_t            r_state, w_stateNext;
  logic [c_CW-1:0]   r_cnt, w_cntNext;
  logic [2:0]        r_idx, w_idxNext;
  logic [c_PW-1:0]   r_pollCnt, w_pollCntNext;
  logic              r_isRead, w_isReadNext;
  logic              r_pollWait, w_pollWaitNext;
  logic              r_wrPending, w_wrPendingNext;
  logic              r_fromHost, w_fromHostNext;
  logic              r_hostRs, w_hostRsNext;
  logic [7:0]        r_hostData, w_hostDataNext;
  logic              r_nCS, w_nCSNext;
  logic              r_nWR, w_nWRNext;
  logic              r_nRD, w_nRDNext;
  logic              r_rs, w_rsNext;
  logic [7:0]        r_dbOut, w_dbOutNext;
  logic              r_dbOe, w_dbOeNext;
  logic              r_hostReady, w_hostReadyNext;
  logic              r_initDone, w_initDoneNext;
  logic              r_err, w_errNext;
  logic              w_startWrite, w_startRead, w_enterPoll;
  logic              w_complete, w_timeout, w_dlyEnd;
  logic              w_unusedDb;

  // Only the busy flag of the status byte matters here
  assign w_unusedDb = ^bus.db_in[6:0];

  assign w_dlyEnd = (r_idx == 3'd0) ? (r_cnt == c_CW'(LONG_CYC - 1))
                                    : (r_cnt == c_CW'(SHORT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= PWR;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_pollCnt   <= '0;
      r_isRead    <= 1'b0;
      r_pollWait  <= 1'b0;
      r_wrPending <= 1'b0;
      r_fromHost  <= 1'b0;
      r_hostRs    <= 1'b0;
      r_hostData  <= 8'h00;
      r_nCS       <= 1'b1;
      r_nWR       <= 1'b1;
      r_nRD       <= 1'b1;
      r_rs        <= 1'b0;
      r_dbOut     <= 8'h00;
      r_dbOe      <= 1'b0;
      r_hostReady <= 1'b0;
      r_initDone  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_cnt       <= w_cntNext;
      r_idx       <= w_idxNext;
      r_pollCnt   <= w_pollCntNext;
      r_isRead    <= w_isReadNext;
      r_pollWait  <= w_pollWaitNext;
      r_wrPending <= w_wrPendingNext;
      r_fromHost  <= w_fromHostNext;
      r_hostRs    <= w_hostRsNext;
      r_hostData  <= w_hostDataNext;
      r_nCS       <= w_nCSNext;
      r_nWR       <= w_nWRNext;
      r_nRD       <= w_nRDNext;
      r_rs        <= w_rsNext;
      r_dbOut     <= w_dbOutNext;
      r_dbOe      <= w_dbOeNext;
      r_hostReady <= w_hostReadyNext;
      r_initDone  <= w_initDoneNext;
      r_err       <= w_errNext;
    end
  end

  always_comb begin
    w_stateNext     = r_state;
    w_cntNext       = r_cnt;
    w_idxNext       = r_idx;
    w_pollCntNext   = r_pollCnt;
    w_isReadNext    = r_isRead;
    w_pollWaitNext  = r_pollWait;
    w_wrPendingNext = r_wrPending;
    w_fromHostNext  = r_fromHost;
    w_hostRsNext    = r_hostRs;
    w_hostDataNext  = r_hostData;
    w_nCSNext       = r_nCS;
    w_nWRNext       = r_nWR;
    w_nRDNext       = r_nRD;
    w_rsNext        = r_rs;
    w_dbOutNext     = r_dbOut;
    w_dbOeNext      = r_dbOe;
    w_hostReadyNext = 1'b0;
    w_initDoneNext  = r_initDone;
    w_errNext       = r_err;
    w_startWrite    = 1'b0;
    w_startRead     = 1'b0;
    w_enterPoll     = 1'b0;
    w_complete      = 1'b0;
    w_timeout       = 1'b0;

    case (r_state)
      PWR: begin
        w_cntNext = r_cnt + c_CW'(1);
        if (r_cnt == c_CW'(PWRUP_CYC - 1)) begin
          w_idxNext    = 3'd0;
          w_startWrite = 1'b1;
        end
      end
      ISSUE: begin
        w_cntNext   = r_cnt + c_CW'(1);
        w_stateNext = ACK;
      end
      ACK: begin
        w_cntNext = r_cnt + c_CW'(1);
        if (!bus.RDY) begin
          w_nCSNext   = 1'b1;
          w_nWRNext   = 1'b1;
          w_nRDNext   = 1'b1;
          w_stateNext = DONE;
        end else if (r_cnt == c_CW'(ACK_TIMEOUT - 1)) begin
          w_nCSNext  = 1'b1;
          w_nWRNext  = 1'b1;
          w_nRDNext  = 1'b1;
          w_errNext  = 1'b1;
          w_complete = 1'b1;
          w_timeout  = 1'b1;
        end
      end
      DONE: begin
        if (bus.RDY) w_complete = 1'b1;
      end
      DELAY: begin
        w_cntNext = r_cnt + c_CW'(1);
        if (w_dlyEnd) begin
          w_idxNext = r_idx + 3'd1;
          if (w_idxNext <= c_LAST_FIXED) w_startWrite = 1'b1;
          else                           w_enterPoll  = 1'b1;
        end
      end
      POLL: begin
        if (r_pollWait) begin
          w_cntNext = r_cnt + c_CW'(1);
          if (r_cnt == c_CW'(POLL_GAP - 1)) w_pollWaitNext = 1'b0;
        end else if (r_wrPending) begin
          w_startWrite = 1'b1;
        end else begin
          w_startRead = 1'b1;
        end
      end
      IDLE: begin
        w_hostReadyNext = 1'b1;
        if (r_hostReady && bus.host_valid) begin
          w_hostReadyNext = 1'b0;
          w_hostRsNext    = bus.host_rs;
          w_hostDataNext  = bus.host_data;
          w_fromHostNext  = 1'b1;
          w_enterPoll     = 1'b1;
        end
      end
      default: w_stateNext = PWR;
    endcase

    if (w_complete) begin
      if (r_isRead) begin
        w_pollCntNext = r_pollCnt + c_PW'(1);
        if (w_timeout) begin
          // Strobes drop this edge; the write waits one all-high cycle in POLL
          w_stateNext     = POLL;
          w_pollWaitNext  = 1'b0;
          w_wrPendingNext = 1'b1;
        end else if (!bus.db_in[7]) begin
          w_startWrite = 1'b1;
        end else if (w_pollCntNext == c_PW'(BF_MAX)) begin
          w_errNext    = 1'b1;
          w_startWrite = 1'b1;
        end else begin
          w_stateNext    = POLL;
          w_pollWaitNext = 1'b1;
        end
      end else if (!r_fromHost && r_idx <= c_LAST_FIXED) begin
        w_stateNext = DELAY;
      end else if (!r_fromHost && r_idx < c_LAST_INIT) begin
        w_idxNext   = r_idx + 3'd1;
        w_enterPoll = 1'b1;
      end else begin
        w_initDoneNext = 1'b1;
        w_dbOeNext     = 1'b0;
        w_stateNext    = IDLE;
      end
    end

    if (w_enterPoll) begin
      w_stateNext     = POLL;
      w_pollWaitNext  = 1'b0;
      w_wrPendingNext = 1'b0;
      w_pollCntNext   = '0;
    end

    if (w_startWrite) begin
      w_stateNext     = ISSUE;
      w_isReadNext    = 1'b0;
      w_wrPendingNext = 1'b0;
      w_pollWaitNext  = 1'b0;
      w_nCSNext       = 1'b0;
      w_nWRNext       = 1'b0;
      w_rsNext        = r_fromHost ? r_hostRs : 1'b0;
      w_dbOutNext     = r_fromHost ? r_hostData : initRom(w_idxNext);
      w_dbOeNext      = 1'b1;
    end

    if (w_startRead) begin
      w_stateNext  = ISSUE;
      w_isReadNext = 1'b1;
      w_nCSNext    = 1'b0;
      w_nRDNext    = 1'b0;
      w_rsNext     = 1'b0;
      w_dbOeNext   = 1'b0;
    end

    // The ISSUE cycle counts toward the ack window, so ISSUE->ACK keeps the count
    if (w_stateNext != r_state && r_state != ISSUE) w_cntNext = '0;
  end

  assign bus.nCS        = r_nCS;
  assign bus.nWR        = r_nWR;
  assign bus.nRD        = r_nRD;
  assign bus.RS         = r_rs;
  assign bus.db_out     = r_dbOut;
  assign bus.db_oe      = r_dbOe;
  assign bus.host_ready = r_hostReady;
  assign bus.init_done  = r_initDone;
  assign bus.err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_lcd_cmd_sequencer
// Brief   : directed bench with a behavioural Lcd_Controller and a scoreboard
// Revision: 1.0
// ============================================================================
module tb_lcd_cmd_sequencer;
  localparam int PWRUP_CYC   = 20;
  localparam int LONG_CYC    = 10;
  localparam int SHORT_CYC   = 4;
  localparam int POLL_GAP    = 2;
  localparam int ACK_TIMEOUT = 8;
  localparam int BF_MAX      = 3;

  localparam int S_NWR = 0, S_RDY = 1, S_NRD = 2, S_DONE = 3, S_HRDY = 4;

  typedef struct packed {
    logic       rd;
    logic       rs;
    logic [7:0] data;
  } tx_t;

  logic clk = 1'b0;
  logic rst;
  int   nChecks = 0;
  int   nFail   = 0;
  int   cyc     = 0;
  tx_t  sbQ[$];

  int   busyPolls = 0;
  int   busyBase  = 0;
  logic stuck     = 1'b0;
  int   noAckReq  = 0;
  int   readCnt   = 0;
  int   noAckUsed = 0;

  lcd_cmd_sequencer_if bus();

  lcd_cmd_sequencer #(
    .PWRUP_CYC  (PWRUP_CYC),
    .LONG_CYC   (LONG_CYC),
    .SHORT_CYC  (SHORT_CYC),
    .POLL_GAP   (POLL_GAP),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .BF_MAX     (BF_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sigVal(input int which);
    case (which)
      S_NWR:   sigVal = bus.nWR;
      S_RDY:   sigVal = bus.RDY;
      S_NRD:   sigVal = bus.nRD;
      S_DONE:  sigVal = bus.init_done;
      default: sigVal = bus.host_ready;
    endcase
  endfunction

  task automatic waitFor(input string tag, input int which, input logic val,
                         input int bound, output int n);
    n = 0;
    while (sigVal(which) !== val && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    if (sigVal(which) !== val) check({"timeout_", tag}, 32'(sigVal(which)), 32'(val));
  endtask

  task automatic pushTx(input logic rd, input logic rs, input logic [7:0] data);
    tx_t t;
    t.rd = rd; t.rs = rs; t.data = data;
    sbQ.push_back(t);
  endtask

  task automatic pushInit();
    pushTx(0, 0, 8'h38); pushTx(0, 0, 8'h38); pushTx(0, 0, 8'h38);
    pushTx(1, 0, 8'h00); pushTx(0, 0, 8'h38);
    pushTx(1, 0, 8'h00); pushTx(0, 0, 8'h0C);
    pushTx(1, 0, 8'h00); pushTx(0, 0, 8'h01);
    pushTx(1, 0, 8'h00); pushTx(0, 0, 8'h06);
  endtask

  task automatic hostWrite(input logic rs, input logic [7:0] data);
    int n;
    waitFor("host_ready_before", S_HRDY, 1'b1, 100, n);
    bus.host_valid = 1'b1; bus.host_rs = rs; bus.host_data = data;
    @(posedge clk); #1;
    bus.host_valid = 1'b0;
    check("host_ready_drop", 32'(bus.host_ready), 0);
    @(posedge clk); #1;
    check("poll_after_accept", 32'(bus.nRD), 0);
    waitFor("host_ready_return", S_HRDY, 1'b1, 800, n);
  endtask

  // Behavioural Lcd_Controller: ack latency 1, done latency 15
  initial begin : controller_model
    tx_t  obs, e;
    int   lastRdEnd;
    logic lastWasRd;
    int   n;
    bus.RDY   = 1'b1;
    bus.db_in = 8'h00;
    lastRdEnd = 0;
    lastWasRd = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (rst && bus.RDY && !bus.nCS && (!bus.nWR || !bus.nRD)) begin
        obs.rd   = !bus.nRD;
        obs.rs   = bus.RS;
        obs.data = obs.rd ? 8'h00 : bus.db_out;
        check("sb_pending", 32'(sbQ.size() > 0), 1);
        if (sbQ.size() > 0) begin
          e = sbQ.pop_front();
          check("sb_tx", {obs.rd, obs.rs, bus.db_oe, obs.data}, {e.rd, e.rs, ~e.rd, e.data});
        end
        if (obs.rd && lastWasRd) check("poll_spacing", cyc - lastRdEnd, POLL_GAP + 2);
        if (obs.rd) begin
          bus.db_in = (stuck || (readCnt - busyBase) < busyPolls) ? 8'h80 : 8'h00;
          readCnt++;
        end
        if (noAckReq != noAckUsed) begin
          noAckUsed = noAckReq;
          n = 0;
          while (!bus.nCS && n < 50) begin
            @(posedge clk); #2;
            n++;
          end
          check("ack_timeout_len", n, ACK_TIMEOUT);
          lastWasRd = 1'b0;
        end else begin
          @(posedge clk); #2;
          bus.RDY = 1'b0;
          repeat (14) begin
            @(posedge clk); #2;
          end
          bus.RDY   = 1'b1;
          lastRdEnd = cyc;
          lastWasRd = obs.rd;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    rst = 1'b0;
    bus.host_valid = 1'b0;
    bus.host_rs    = 1'b0;
    bus.host_data  = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {bus.nCS, bus.nWR, bus.nRD, bus.RS, bus.db_oe, bus.host_ready, bus.init_done, bus.err, bus.db_out},
          {8'b1110_0000, 8'h00});

    // Power-on init
    pushInit();
    @(negedge clk); rst = 1'b1;
    waitFor("first_nwr", S_NWR, 1'b0, 100, n);
    check("pwrup_to_first_nwr", n, PWRUP_CYC);
    check("first_write_bus", {bus.RS, bus.db_out}, {1'b0, 8'h38});
    waitFor("rdy_fall0", S_RDY, 1'b0, 50, n);
    waitFor("rdy_rise0", S_RDY, 1'b1, 50, n);
    waitFor("second_nwr", S_NWR, 1'b0, 100, n);
    check("gap_long", n, LONG_CYC);
    waitFor("rdy_fall1", S_RDY, 1'b0, 50, n);
    waitFor("rdy_rise1", S_RDY, 1'b1, 50, n);
    waitFor("third_nwr", S_NWR, 1'b0, 100, n);
    check("gap_short", n, SHORT_CYC);
    waitFor("init_done", S_DONE, 1'b1, 2000, n);
    @(posedge clk); #1;
    check("idle_after_init", {bus.init_done, bus.host_ready, bus.err, bus.db_oe}, 4'b1100);
    check("sb_init_empty", sbQ.size(), 0);

    // Plain host character write
    pushTx(1, 0, 8'h00); pushTx(0, 1, 8'h41);
    hostWrite(1'b1, 8'h41);
    check("host_write_err", 32'(bus.err), 0);
    check("sb_host_empty", sbQ.size(), 0);

    // Busy for two polls, then clear
    busyBase = readCnt; busyPolls = 2;
    pushTx(1, 0, 8'h00); pushTx(1, 0, 8'h00); pushTx(1, 0, 8'h00); pushTx(0, 0, 8'h01);
    hostWrite(1'b0, 8'h01);
    busyPolls = 0;
    check("busy2_err", 32'(bus.err), 0);
    check("sb_busy2_empty", sbQ.size(), 0);

    // Controller never acks the poll read
    noAckReq = noAckReq + 1;
    pushTx(1, 0, 8'h00); pushTx(0, 1, 8'h42);
    hostWrite(1'b1, 8'h42);
    check("timeout_err", 32'(bus.err), 1);
    check("sb_timeout_empty", sbQ.size(), 0);

    // Reset while a write strobe is low
    pushTx(1, 0, 8'h00); pushTx(0, 1, 8'h43);
    waitFor("host_ready_rst", S_HRDY, 1'b1, 100, n);
    bus.host_valid = 1'b1; bus.host_rs = 1'b1; bus.host_data = 8'h43;
    @(posedge clk); #1;
    bus.host_valid = 1'b0;
    waitFor("nwr_before_rst", S_NWR, 1'b0, 200, n);
    rst = 1'b0;
    #1;
    check("reset_async", {bus.nCS, bus.nWR, bus.db_oe, bus.host_ready, bus.err}, 5'b11000);
    sbQ.delete();
    pushInit();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    waitFor("restart_nwr", S_NWR, 1'b0, 100, n);
    check("restart_pwrup", n, PWRUP_CYC);
    waitFor("reinit_done", S_DONE, 1'b1, 2000, n);
    check("reinit_err_clear", 32'(bus.err), 0);
    check("sb_reinit_empty", sbQ.size(), 0);

    // Busy flag stuck high
    stuck = 1'b1;
    pushTx(1, 0, 8'h00); pushTx(1, 0, 8'h00); pushTx(1, 0, 8'h00); pushTx(0, 0, 8'h0C);
    hostWrite(1'b0, 8'h0C);
    stuck = 1'b0;
    check("stuck_err", 32'(bus.err), 1);
    check("sb_stuck_empty", sbQ.size(), 0);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
`default_nettype wire
